// File: rtl/aes_encipher_seq.sv
// aes_encipher_seq: iterative AES block encipher, one shared 32-bit S-box.
// Define AES_ENC_256_EN to let keylen select 14 rounds; default is AES-128 only.
module aes_encipher_seq (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic         keylen,
   input  logic [127:0] block,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   output logic [127:0] new_block,
   output logic         ready
);

   typedef enum logic [1:0] {IDLE, SBOX, MAIN} state_t;

   state_t       state_q, state_d;
   logic [127:0] block_q, block_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   sword_q, sword_d;
   logic         ready_q, ready_d;
   logic [3:0]   num_rounds;

`ifdef AES_ENC_256_EN
   logic klen_q, klen_d;
   assign num_rounds = klen_q ? 4'd14 : 4'd10;
`else
   logic unused_keylen;
   assign unused_keylen = keylen;
   assign num_rounds    = 4'd10;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // byte (row r, col c) sits at index 4c+r, MSB first
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   // state register, async clear abandons any run in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         block_q <= '0;
         round_q <= '0;
         sword_q <= '0;
         ready_q <= 1'b1;
`ifdef AES_ENC_256_EN
         klen_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         block_q <= block_d;
         round_q <= round_d;
         sword_q <= sword_d;
         ready_q <= ready_d;
`ifdef AES_ENC_256_EN
         klen_q  <= klen_d;
`endif
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      block_d = block_q;
      round_d = round_q;
      sword_d = sword_q;
      ready_d = ready_q;
`ifdef AES_ENC_256_EN
      klen_d  = klen_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (next) begin
               block_d = block ^ round_key;
               round_d = 4'd1;
               sword_d = 2'd0;
               ready_d = 1'b0;
               state_d = SBOX;
`ifdef AES_ENC_256_EN
               klen_d  = keylen;
`endif
            end
         end
         SBOX: begin
            unique case (sword_q)
               2'd0:    block_d[127:96] = new_sboxw;
               2'd1:    block_d[95:64]  = new_sboxw;
               2'd2:    block_d[63:32]  = new_sboxw;
               default: block_d[31:0]   = new_sboxw;
            endcase
            sword_d = sword_q + 2'd1;
            if (sword_q == 2'd3)
               state_d = MAIN;
         end
         MAIN: begin
            if (round_q < num_rounds) begin
               block_d = mix_columns(shift_rows(block_q)) ^ round_key;
               round_d = round_q + 4'd1;
               state_d = SBOX;
            end else begin
               block_d = shift_rows(block_q) ^ round_key;
               round_d = 4'd0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // S-box word select
   always_comb begin
      unique case (sword_q)
         2'd0:    sboxw = block_q[127:96];
         2'd1:    sboxw = block_q[95:64];
         2'd2:    sboxw = block_q[63:32];
         default: sboxw = block_q[31:0];
      endcase
   end

   assign round     = round_q;
   assign new_block = block_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_seq.sv
// tb_aes_encipher_seq: bench for aes_encipher_seq with key-schedule,
// S-box and byte-level AES reference models.
module tb_aes_encipher_seq;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         next = 1'b0;
   logic         keylen = 1'b0;
   logic [127:0] block = '0;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] new_block;
   logic         ready;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] rk [0:15];
   int           nr_m;
   logic [3:0]   rq [$];

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   always #5 clk = ~clk;

   assign round_key = rk[round];
   assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]],
                       sbox_t[sboxw[15:8]],  sbox_t[sboxw[7:0]]};

   aes_encipher_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .keylen    (keylen),
      .block     (block),
      .round     (round),
      .round_key (round_key),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .new_block (new_block),
      .ready     (ready)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
         end
         b = inv;
         sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                   ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic load_key(input logic [255:0] key, input bit k256);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk;
      nk = k256 ? 8 : 4;
      nr_m = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 4 * (nr_m + 1); i++) begin
         if (i < nk) w[i] = key[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r < 16; r++) begin
         rk[r] = '0;
         if (r <= nr_m) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] blk);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] k, o;
      logic [7:0]   a0, a1, a2, a3;
      k = rk[0];
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int r = 1; r <= nr_m; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < nr_m) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         k = rk[r];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // runs one block from a negedge; lat counts the start edge as edge 1
   task automatic do_run(input logic kl, input logic [127:0] blk,
                         input bit hold, input bit tog,
                         output logic [127:0] res, output int lat);
      int n;
      rq.delete();
      keylen = kl;
      block  = blk;
      next   = 1'b1;
      rq.push_back(round);
      @(posedge clk);
      n = 1;
      forever begin
         @(negedge clk);
         rq.push_back(round);
         if (ready || n >= 200) break;
         next  = hold;
         block = rnd128();
         if (tog) keylen = ~keylen;
         @(posedge clk);
         n++;
      end
      next = 1'b0;
      res  = new_block;
      lat  = n;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ready, round, sboxw, new_block} !== {1'b1, 4'd0, 32'd0, 128'd0}) begin
         n_bad++;
         $display("FAIL reset: ready=%b round=%0d sboxw=%h nb=%h want 1/0/0/0",
                  ready, round, sboxw, new_block);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_aes128();
      logic [127:0] res, pt, exp;
      logic [255:0] key;
      int lat;
      load_key({K128, 128'h0}, 1'b0);
      do_run(1'b0, PT, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (res !== CT1) begin
         n_bad++;
         $display("FAIL aes128_vec: got %h want %h", res, CT1);
      end
      n_cmp++;
      if (lat !== 51) begin
         n_bad++;
         $display("FAIL aes128_lat: got %0d want 51", lat);
      end
      for (int i = 0; i < 3; i++) begin
         key = {rnd128(), 128'h0};
         pt  = rnd128();
         load_key(key, 1'b0);
         exp = ref_enc(pt);
         do_run(1'b0, pt, 1'b0, 1'b0, res, lat);
         n_cmp++;
         if (res !== exp || lat !== 51) begin
            n_bad++;
            $display("FAIL aes128_rand%0d: got %h lat %0d want %h lat 51",
                     i, res, lat, exp);
         end
      end
   endtask

`ifdef AES_ENC_256_EN
   task automatic test_aes256();
      logic [127:0] res, pt, exp;
      logic [255:0] key;
      int lat;
      key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      load_key(key, 1'b1);
      do_run(1'b1, PT, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (res !== 128'h8ea2b7ca516745bfeafc49904b496089 || lat !== 71) begin
         n_bad++;
         $display("FAIL aes256_vec: got %h lat %0d want 8ea2b7ca516745bfeafc49904b496089 lat 71",
                  res, lat);
      end
      for (int i = 0; i < 2; i++) begin
         key = {rnd128(), rnd128()};
         pt  = rnd128();
         load_key(key, 1'b1);
         exp = ref_enc(pt);
         do_run(1'b1, pt, 1'b0, 1'b0, res, lat);
         n_cmp++;
         if (res !== exp || lat !== 71) begin
            n_bad++;
            $display("FAIL aes256_rand%0d: got %h lat %0d want %h lat 71",
                     i, res, lat, exp);
         end
      end
   endtask
`else
   task automatic test_keylen_ignored();
      logic [127:0] res;
      int lat, maxr;
      load_key({K128, 128'h0}, 1'b0);
      do_run(1'b1, PT, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (res !== CT1 || lat !== 51) begin
         n_bad++;
         $display("FAIL keylen_ign: got %h lat %0d want %h lat 51", res, lat, CT1);
      end
      maxr = 0;
      foreach (rq[i]) if (int'(rq[i]) > maxr) maxr = int'(rq[i]);
      n_cmp++;
      if (maxr !== 10) begin
         n_bad++;
         $display("FAIL keylen_maxround: got %0d want 10", maxr);
      end
   endtask
`endif

   task automatic test_hold_next();
      logic [127:0] res;
      int lat;
      load_key({K128, 128'h0}, 1'b0);
      do_run(1'b0, PT, 1'b1, 1'b1, res, lat);
      n_cmp++;
      if (res !== CT1 || lat !== 51) begin
         n_bad++;
         $display("FAIL hold_next: got %h lat %0d want %h lat 51", res, lat, CT1);
      end
      block = rnd128();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ready !== 1'b1 || new_block !== CT1) begin
         n_bad++;
         $display("FAIL hold_result: ready=%b nb=%h want 1 %h", ready, new_block, CT1);
      end
   endtask

   task automatic test_reset_midrun();
      logic [127:0] res;
      int lat;
      load_key({K128, 128'h0}, 1'b0);
      keylen = 1'b0;
      block  = PT;
      next   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      next = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_busy: ready=%b want 0", ready);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({ready, round, new_block} !== {1'b1, 4'd0, 128'd0}) begin
         n_bad++;
         $display("FAIL midrun_async: ready=%b round=%0d nb=%h want 1/0/0",
                  ready, round, new_block);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_run(1'b0, PT, 1'b0, 1'b0, res, lat);
      n_cmp++;
      if (res !== CT1 || lat !== 51) begin
         n_bad++;
         $display("FAIL midrun_rerun: got %h lat %0d want %h lat 51", res, lat, CT1);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] res, pt, exp;
      int lat;
      bit ok;
      load_key({rnd128(), 128'h0}, 1'b0);
      for (int run = 0; run < 2; run++) begin
         pt  = rnd128();
         exp = ref_enc(pt);
         do_run(1'b0, pt, 1'b0, 1'b0, res, lat);
         n_cmp++;
         if (res !== exp || lat !== 51) begin
            n_bad++;
            $display("FAIL b2b_res%0d: got %h lat %0d want %h lat 51",
                     run, res, lat, exp);
         end
         ok = (rq.size() == 52) && (rq[0] == 4'd0) && (rq[51] == 4'd0);
         for (int n = 1; n <= 50 && n < rq.size(); n++)
            if (int'(rq[n]) != (n - 1) / 5 + 1) ok = 1'b0;
         n_cmp++;
         if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_rounds%0d: sequence len %0d not 0,1x5..10x5,0",
                     run, rq.size());
         end
      end
   endtask

   initial begin
      build_sbox();
      for (int r = 0; r < 16; r++) rk[r] = '0;
      test_reset();
      test_aes128();
`ifdef AES_ENC_256_EN
      test_aes256();
`else
      test_keylen_ignored();
`endif
      test_hold_next();
      test_reset_midrun();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
